// File: rtl/dac_pkg.sv
// dac_pkg: shared state encodings, frame layout and power-down codes for serial_dac_writer (rev 1.0)
`default_nettype none

package dac_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } dac_state_e;

  localparam int FRAME_W   = 16;
  localparam int CODE_W    = 8;
  localparam int BIT_CNT_W = 4;
  localparam int PD_LSB    = 12;
  localparam int PD_MSB    = 13;
  localparam int DATA_LSB  = 4;
  localparam int DATA_MSB  = 11;

  localparam logic [1:0] PD_NORMAL    = 2'b00;
  localparam logic [1:0] PD_1K_GND    = 2'b01;
  localparam logic [1:0] PD_100K_GND  = 2'b10;
  localparam logic [1:0] PD_TRISTATE  = 2'b11;

  // Frame layout: {2'b00, pd[1:0], code[7:0], 4'b0000}
  function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0]        pd,
                                                     input logic [CODE_W-1:0] code);
    logic [FRAME_W-1:0] f;
    f                    = '0;
    f[PD_MSB:PD_LSB]     = pd;
    f[DATA_MSB:DATA_LSB] = code;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dac_frame_shifter.sv
// dac_frame_shifter: 16-bit MSB-first load/shift register with bit counter (rev 1.0)
`default_nettype none

module dac_frame_shifter
  import dac_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic               shift,
  input  logic [FRAME_W-1:0] frame_in,
  output logic               sdata,
  output logic               last
);

  localparam logic [BIT_CNT_W-1:0] CNT_TOP = BIT_CNT_W'(FRAME_W - 1);
  localparam logic [BIT_CNT_W-1:0] CNT_ONE = BIT_CNT_W'(1);

  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;

  // Zeros shift in from the bottom, so the final shift leaves sdata low.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = frame_in;
      cnt_d   = CNT_TOP;
    end else if (shift) begin
      shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
      cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sdata = shreg_q[FRAME_W-1];
  assign last  = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/serial_dac_writer.sv
// serial_dac_writer: ready/enable handshake to 3-wire AD5300-style serial DAC frame (rev 1.0)
`default_nettype none

module serial_dac_writer
  import dac_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        pd_mode,
  output logic              dac_rdy,
  output logic              done,
  output logic              sclk,
  output logic              sync_n,
  output logic              sdata
);

  localparam int                 GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_ONE  = GAP_W'(1);

  dac_state_e       state_q, state_d;
  logic             phase_q, phase_d;
  logic             sclk_q, sclk_d;
  logic             sync_n_q, sync_n_d;
  logic             dac_rdy_q, dac_rdy_d;
  logic             done_q, done_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic               sh_load;
  logic               sh_shift;
  logic               sh_last;
  logic [FRAME_W-1:0] frame;

  assign frame = build_frame(pd_mode, CODE_W'(data_in));

  dac_frame_shifter u_shifter (
    .clk      (clk),
    .resetn   (resetn),
    .load     (sh_load),
    .shift    (sh_shift),
    .frame_in (frame),
    .sdata    (sdata),
    .last     (sh_last)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    sclk_d    = sclk_q;
    sync_n_d  = sync_n_q;
    dac_rdy_d = dac_rdy_q;
    done_d    = 1'b0;
    gap_d     = gap_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;

    case (state_q)
      ST_RST: begin
        state_d   = ST_IDLE;
        dac_rdy_d = 1'b1;
      end

      ST_IDLE: begin
        dac_rdy_d = 1'b1;
        if (wr_en) begin
          sh_load   = 1'b1;
          dac_rdy_d = 1'b0;
          sync_n_d  = 1'b0;
          sclk_d    = 1'b1;
          phase_d   = 1'b0;
          state_d   = ST_SHIFT;
        end
      end

      // Phase 0 drops SCLK (DAC samples); phase 1 raises it and moves to the next bit.
      ST_SHIFT: begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          sclk_d = 1'b0;
        end else begin
          sclk_d   = 1'b1;
          sh_shift = 1'b1;
          if (sh_last) begin
            sync_n_d = 1'b1;
            gap_d    = GAP_LOAD;
            state_d  = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          state_d   = ST_IDLE;
          dac_rdy_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end

      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_RST;
      phase_q   <= 1'b0;
      sclk_q    <= 1'b1;
      sync_n_q  <= 1'b1;
      dac_rdy_q <= 1'b0;
      done_q    <= 1'b0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      sclk_q    <= sclk_d;
      sync_n_q  <= sync_n_d;
      dac_rdy_q <= dac_rdy_d;
      done_q    <= done_d;
      gap_q     <= gap_d;
    end
  end

  assign sclk    = sclk_q;
  assign sync_n  = sync_n_q;
  assign dac_rdy = dac_rdy_q;
  assign done    = done_q;

endmodule

`default_nettype wire
